// File: rtl/pong_pkg.sv
// Shared Pong display definitions: BCD digit type, active-low {g..a} segment
// patterns, the scoreboard FSM state type and BCD helper functions.
package pong_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    PLAY,
    OVER
  } sb_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] seg7_decode(input bcd_t digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Binary to packed BCD, up to four digits (digit 0 in the low nibble).
  function automatic logic [15:0] to_bcd(input int unsigned value);
    logic [15:0] result;
    int unsigned rest;
    result = '0;
    rest   = value;
    for (int unsigned i = 0; i < 4; i++) begin
      result[i*4 +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD point counter; saturates at WIN_SCORE when it is non-zero,
// otherwise wraps all-nines to zero. at_win flags the post-increment value.
import pong_pkg::*;

module bcd_counter #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [DIGITS*4-1:0]   value,
  output logic                  at_win
);

  localparam logic [15:0]          WIN_FULL = to_bcd(WIN_SCORE);
  localparam logic [DIGITS*4-1:0]  WIN_BCD  = WIN_FULL[DIGITS*4-1:0];

  logic [DIGITS*4-1:0] cnt_q, cnt_d;
  logic                carry;
  bcd_t                digit;

  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b1;
    digit = '0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(WIN_SCORE != 0 && cnt_q == WIN_BCD)) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        digit = cnt_q[d*4 +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            cnt_d[d*4 +: 4] = '0;
          end else begin
            cnt_d[d*4 +: 4] = digit + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value  = cnt_q;
  assign at_win = (WIN_SCORE != 0) && (cnt_d == WIN_BCD);

endmodule

// File: rtl/score_board.sv
// Pong scoreboard: per-player BCD scores, PLAY/OVER win FSM, 7-segment decode.
// Optional winner blinking is enabled by defining SCORE_BOARD_BLINK_EN.
import pong_pkg::*;

module score_board #(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned WIN_SCORE  = 11,
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [PLAYERS-1:0]                           point,
  input  logic                                         clear,
  output logic [PLAYERS*DIGITS*7-1:0]                  hex,
  output logic                                         game_over,
  output logic [((PLAYERS > 1) ? $clog2(PLAYERS) : 1)-1:0] winner
);

  localparam int unsigned WW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

  if (PLAYERS < 1 || PLAYERS > 8 || DIGITS < 1 || DIGITS > 4 ||
      WIN_SCORE >= 10**DIGITS || BLINK_HALF < 1) begin : g_bad_params
    $error("score_board: parameter out of range");
  end

  logic [PLAYERS-1:0][DIGITS*4-1:0] score;
  logic [PLAYERS-1:0]               hit;
  logic [PLAYERS-1:0]               inc;
  sb_state_e                        state_q;
  logic                             game_over_q;
  logic [WW-1:0]                    winner_q, winner_d;
  logic                             blank_phase;

  // Points only count while playing, and clear always wins over a point.
  assign inc = (state_q == PLAY && !clear) ? point : '0;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    bcd_counter #(
      .DIGITS    (DIGITS),
      .WIN_SCORE (WIN_SCORE)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[p]),
      .clr    (clear),
      .value  (score[p]),
      .at_win (hit[p])
    );
  end

  always_comb begin
    winner_d = '0;
    for (int unsigned i = PLAYERS; i > 0; i--) begin
      if (hit[i-1]) winner_d = WW'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= PLAY;
      game_over_q <= 1'b0;
      winner_q    <= '0;
    end else if (state_q == PLAY && |hit) begin
      state_q     <= OVER;
      game_over_q <= 1'b1;
      winner_q    <= winner_d;
    end
  end

`ifdef SCORE_BOARD_BLINK_EN
  localparam int unsigned     BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blank_phase = phase_q && (state_q == OVER);
`else
  assign blank_phase = 1'b0;
`endif

  always_comb begin
    hex = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (blank_phase && winner_q == WW'(p))
          hex[(p*DIGITS+d)*7 +: 7] = SEG_BLANK;
        else
          hex[(p*DIGITS+d)*7 +: 7] = seg7_decode(score[p][d*4 +: 4]);
      end
    end
  end

  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_board.sv
// Self-checking bench for score_board: a default win-at-11 instance and a
// WIN_SCORE=0 wrapping instance, checked against an arithmetic score model.
module tb_score_board;

  localparam int P   = 2;
  localparam int D   = 2;
  localparam int WIN = 11;
  localparam int H   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  point = '0;
  logic        clear = 1'b0;
  logic [27:0] hex;
  logic        game_over;
  logic [0:0]  winner;
  logic [1:0]  point_w = '0;
  logic        clear_w = 1'b0;
  logic [27:0] hex_w;
  logic        go_w;
  logic [0:0]  winner_w;

  always #5 clk = ~clk;

  score_board #(.PLAYERS(P), .DIGITS(D), .WIN_SCORE(WIN), .BLINK_HALF(H)) dut (
    .clk(clk), .rst(rst), .point(point), .clear(clear),
    .hex(hex), .game_over(game_over), .winner(winner));

  score_board #(.PLAYERS(P), .DIGITS(D), .WIN_SCORE(0), .BLINK_HALF(H)) dut_w (
    .clk(clk), .rst(rst), .point(point_w), .clear(clear_w),
    .hex(hex_w), .game_over(go_w), .winner(winner_w));

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S9 = 7'b0010000;

  // Reference model: plain integer scores and game state.
  int m_score [2];
  bit m_over;
  int m_win;
  int m_blink;
  int w_score [2];

  typedef struct {
    logic [1:0] pt;
    bit         clr;
    int         s0;
    int         s1;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [27:0] hex_from(input int s0, input int s1, input int blank_p);
    logic [27:0] h;
    int s;
    h = '0;
    for (int p = 0; p < 2; p++) begin
      s = (p == 0) ? s0 : s1;
      for (int d = 0; d < 2; d++)
        h[(p*2+d)*7 +: 7] = (p == blank_p) ? 7'b1111111 : seg_tab[((d == 0) ? s : s / 10) % 10];
    end
    return h;
  endfunction

  function automatic int blank_p();
`ifdef SCORE_BOARD_BLINK_EN
    return (m_over && ((m_blink / H) % 2 == 1)) ? m_win : -1;
`else
    return -1;
`endif
  endfunction

  function automatic void model_step(input bit r, input logic [1:0] pt, input bit clr,
                                     input logic [1:0] ptw, input bit clrw);
    if (r || clr) begin
      m_score[0] = 0; m_score[1] = 0; m_over = 0; m_win = 0; m_blink = 0;
    end else begin
      m_blink++;
      if (!m_over) begin
        for (int i = 0; i < 2; i++) if (pt[i]) m_score[i]++;
        for (int i = 0; i < 2; i++)
          if (!m_over && m_score[i] == WIN) begin m_over = 1; m_win = i; end
      end
    end
    if (r || clrw) begin
      w_score[0] = 0; w_score[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) if (ptw[i]) w_score[i] = (w_score[i] + 1) % 100;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input bit r, input logic [1:0] pt, input bit clr,
                      input logic [1:0] ptw, input bit clrw);
    rst = r; point = pt; clear = clr; point_w = ptw; clear_w = clrw;
    @(posedge clk);
    #1;
    model_step(r, pt, clr, ptw, clrw);
    rst = 1'b0; point = '0; clear = 1'b0; point_w = '0; clear_w = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, " hex"},       64'(hex), 64'(hex_from(m_score[0], m_score[1], blank_p())));
    check({tag, " game_over"}, 64'(game_over), 64'(m_over));
    check({tag, " winner"},    64'(winner), 64'(m_win));
    check({tag, " hex_w"},     64'(hex_w), 64'(hex_from(w_score[0], w_score[1], -1)));
    check({tag, " go_w"},      64'(go_w), 64'(0));
  endtask

  initial begin
    vecs[0] = '{2'b01, 1'b0, 1, 0};
    vecs[1] = '{2'b10, 1'b0, 1, 1};
    vecs[2] = '{2'b11, 1'b0, 2, 2};
    vecs[3] = '{2'b11, 1'b1, 0, 0};
    vecs[4] = '{2'b01, 1'b0, 1, 0};
    vecs[5] = '{2'b00, 1'b0, 1, 0};

    tick(1, '0, 0, '0, 0);
    tick(1, '0, 0, '0, 0);
    check("reset hex", 64'(hex), 64'({4{S0}}));
    check("reset game_over", 64'(game_over), 64'(0));
    check("reset winner", 64'(winner), 64'(0));
    check("reset hex_w", 64'(hex_w), 64'({4{S0}}));

    for (int i = 0; i < 6; i++) begin
      tick(0, vecs[i].pt, vecs[i].clr, '0, 0);
      check($sformatf("vec%0d hex", i), 64'(hex), 64'(hex_from(vecs[i].s0, vecs[i].s1, -1)));
      check($sformatf("vec%0d game_over", i), 64'(game_over), 64'(0));
    end

    tick(0, '0, 1, '0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 2'b01, 0, '0, 0);
      tick(0, 2'b00, 0, '0, 0);
    end
    check("p0 ten", 64'(hex[13:0]), 64'({S1, S0}));
    check("p1 zero", 64'(hex[27:14]), 64'({S0, S0}));

    for (int i = 0; i < 10; i++) tick(0, 2'b10, 0, '0, 0);
    check("both ten", 64'(hex), 64'(hex_from(10, 10, -1)));
    check("ten game_over", 64'(game_over), 64'(0));

    tick(0, 2'b11, 0, '0, 0);
    check("tie game_over", 64'(game_over), 64'(1));
    check("tie winner", 64'(winner), 64'(0));
    check("tie hex", 64'(hex), 64'(hex_from(11, 11, blank_p())));
    for (int i = 0; i < 5; i++) begin
      tick(0, 2'b11, 0, '0, 0);
      check("frozen hex", 64'(hex), 64'(hex_from(11, 11, blank_p())));
      check("frozen game_over", 64'(game_over), 64'(1));
    end

    tick(0, 2'b10, 1, '0, 0);
    check("clear hex", 64'(hex), 64'({4{S0}}));
    check("clear game_over", 64'(game_over), 64'(0));
    check("clear winner", 64'(winner), 64'(0));
    tick(0, 2'b00, 0, '0, 0);
    check("clear point dropped", 64'(hex), 64'({4{S0}}));

    for (int i = 0; i < 10; i++) tick(0, 2'b10, 0, '0, 0);
    check("p1 ten not over", 64'(game_over), 64'(0));
    tick(0, 2'b10, 0, '0, 0);
    check("p1 win game_over", 64'(game_over), 64'(1));
    check("p1 win winner", 64'(winner), 64'(1));
    for (int i = 0; i < 16; i++) begin
      tick(0, 2'b11, 0, '0, 0);
      check("blink hex", 64'(hex), 64'(hex_from(0, 11, blank_p())));
      check("loser steady", 64'(hex[13:0]), 64'({S0, S0}));
    end

    tick(0, '0, 1, '0, 0);
    for (int i = 0; i < 5; i++) tick(0, 2'b01, 0, '0, 0);
    tick(1, 2'b11, 0, '0, 0);
    check("midgame reset hex", 64'(hex), 64'({4{S0}}));
    check("midgame reset game_over", 64'(game_over), 64'(0));
    tick(0, 2'b01, 0, '0, 0);
    check("after reset count", 64'(hex), 64'(hex_from(1, 0, -1)));

    for (int i = 0; i < 99; i++) tick(0, '0, 0, 2'b10, 0);
    check("wrap 99", 64'(hex_w[27:14]), 64'({S9, S9}));
    tick(0, '0, 0, 2'b10, 0);
    check("wrap 00", 64'(hex_w), 64'({4{S0}}));
    check("wrap go", 64'(go_w), 64'(0));

    for (int c = 0; c < 3000; c++) begin
      logic [1:0] pt, ptw;
      bit r, clr, clrw;
      r    = ($urandom_range(0, 999) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      clrw = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        pt[i]  = ($urandom_range(0, 2) == 0);
        ptw[i] = ($urandom_range(0, 1) == 0);
      end
      tick(r, pt, clr, ptw, clrw);
      check_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
